// File: rtl/mod_addsub_pipe.sv
// -----------------------------------------------------------------------------
// mod_addsub_pipe
//
// Pipelined add/subtract unit with a valid/ready handshake on both sides.
// The operation is computed in stage 0 at DATA_W+1 bits. The remaining stages
// only delay the result. Each stage loads whenever it is empty or the stage
// after it is loading, so empty slots fill even while the output is stalled.
// A 16-bit saturating counter records overflowed beats handed downstream.
//
// Handshake: a beat moves on a rising clk edge when its valid and the matching
// ready are both high. Once a beat is valid it is held stable until it is
// taken. o_ready is combinational and may depend on i_ready.
//
// Parameters:
//   DATA_W  operand/result width (2..32)
//   STAGES  pipeline register stages, output register included (1..4)
//   SAT_EN  1 = clamp on overflow, 0 = wrap modulo 2^DATA_W
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_x      asynchronous active-low reset
//   i_valid    input beat valid
//   o_ready    unit can accept an input beat this cycle
//   i_op       0 = a+b, 1 = a-b (sampled with the beat)
//   i_signed   1 = two's-complement operands, 0 = unsigned
//   i_in_a     operand a
//   i_in_b     operand b
//   o_valid    output beat valid
//   i_ready    downstream accepts the output beat
//   o_out      result
//   o_ovf      overflow flag aligned with o_out
//   i_cnt_clr  synchronous clear of o_ovf_cnt (wins over increment)
//   o_ovf_cnt  saturating count of overflowed beats delivered
// -----------------------------------------------------------------------------
module mod_addsub_pipe #(
    parameter int DATA_W = 8,
    parameter int STAGES = 2,
    parameter int SAT_EN = 1
) (
    input  logic              clk,
    input  logic              rst_x,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_op,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_in_a,
    input  logic [DATA_W-1:0] i_in_b,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_out,
    output logic              o_ovf,
    input  logic              i_cnt_clr,
    output logic [15:0]       o_ovf_cnt
);

    localparam int LAST = STAGES - 1;

    // Pipeline state
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] ovf_q, ovf_d;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];
    logic [15:0]       cnt_q, cnt_d;

    // Per-stage load enables
    logic [STAGES-1:0] en;
    logic              en_run;
    logic              accept;
    logic              cnt_inc;

    // Stage-0 arithmetic
    logic [DATA_W:0]   ext_a, ext_b, raw;
    logic [DATA_W-1:0] sat_val, res;
    logic              res_ovf;

    // Enable chain from the output backwards: a stage may load if it is empty
    // or its contents are moving on this cycle.
    always_comb begin
        en     = '0;
        en_run = i_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            en_run = ~v_q[k] | en_run;
            en[k]  = en_run;
        end
    end

    assign o_ready = en[0];
    assign accept  = i_valid & en[0];

    // Extend one bit so the top bit of raw carries carry/borrow (unsigned)
    // or the true sign of the result (signed).
    always_comb begin
        ext_a = i_signed ? {i_in_a[DATA_W-1], i_in_a} : {1'b0, i_in_a};
        ext_b = i_signed ? {i_in_b[DATA_W-1], i_in_b} : {1'b0, i_in_b};
        raw   = i_op ? (ext_a - ext_b) : (ext_a + ext_b);

        if (i_signed) begin
            // Result does not fit when the true sign differs from the
            // sign bit of the truncated result.
            res_ovf = raw[DATA_W] ^ raw[DATA_W-1];
            sat_val = raw[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                  : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            // Add: carry out. Subtract: borrow, i.e. a < b.
            res_ovf = raw[DATA_W];
            sat_val = i_op ? '0 : '1;
        end

        if ((SAT_EN != 0) && res_ovf) begin
            res = sat_val;
        end else begin
            res = raw[DATA_W-1:0];
        end
    end

    // Next-state for every stage
    always_comb begin
        v_d   = v_q;
        ovf_d = ovf_q;
        for (int k = 0; k < STAGES; k++) begin
            data_d[k] = data_q[k];
        end

        if (en[0]) begin
            v_d[0] = accept;
            if (accept) begin
                data_d[0] = res;
                ovf_d[0]  = res_ovf;
            end
        end

        for (int k = 1; k < STAGES; k++) begin
            if (en[k]) begin
                v_d[k]    = v_q[k-1];
                data_d[k] = data_q[k-1];
                ovf_d[k]  = ovf_q[k-1];
            end
        end
    end

    // Overflow event counter, counted only on a completed output handshake
    assign cnt_inc = v_q[LAST] & i_ready & ovf_q[LAST];

    always_comb begin
        cnt_d = cnt_q;
        if (i_cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            v_q   <= '0;
            ovf_q <= '0;
            cnt_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign o_valid   = v_q[LAST];
    assign o_out     = data_q[LAST];
    assign o_ovf     = ovf_q[LAST];
    assign o_ovf_cnt = cnt_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_mod_addsub_pipe
//
// Two instances share all inputs: u_dut clamps on overflow, u_dut_w wraps.
// Each accepted beat pushes {ovf, wrapped, clamped} into exp_q; a monitor on
// the falling edge pops on every output handshake and also tracks the
// overflow counter and output stability while stalled.
// -----------------------------------------------------------------------------
module tb_mod_addsub_pipe;

  localparam int W      = 8;
  localparam int STAGES = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_x = 1'b0;
  always #5 clk = ~clk;

  logic         i_valid = 1'b0;
  logic         i_op = 1'b0;
  logic         i_signed = 1'b0;
  logic [W-1:0] i_in_a = '0;
  logic [W-1:0] i_in_b = '0;
  logic         i_ready = 1'b1;
  logic         i_cnt_clr = 1'b0;

  logic         o_ready, o_valid, o_ovf;
  logic [W-1:0] o_out;
  logic [15:0]  o_ovf_cnt;
  logic         o_ready_w, o_valid_w, o_ovf_w;
  logic [W-1:0] o_out_w;
  logic [15:0]  o_ovf_cnt_w;

  mod_addsub_pipe #(.DATA_W(W), .STAGES(STAGES), .SAT_EN(1)) u_dut (
    .clk(clk), .rst_x(rst_x), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_signed(i_signed), .i_in_a(i_in_a), .i_in_b(i_in_b),
    .o_valid(o_valid), .i_ready(i_ready), .o_out(o_out), .o_ovf(o_ovf),
    .i_cnt_clr(i_cnt_clr), .o_ovf_cnt(o_ovf_cnt)
  );

  mod_addsub_pipe #(.DATA_W(W), .STAGES(STAGES), .SAT_EN(0)) u_dut_w (
    .clk(clk), .rst_x(rst_x), .i_valid(i_valid), .o_ready(o_ready_w),
    .i_op(i_op), .i_signed(i_signed), .i_in_a(i_in_a), .i_in_b(i_in_b),
    .o_valid(o_valid_w), .i_ready(i_ready), .o_out(o_out_w), .o_ovf(o_ovf_w),
    .i_cnt_clr(i_cnt_clr), .o_ovf_cnt(o_ovf_cnt_w)
  );

  // scoreboard: {ovf, wrapped result, clamped result}
  logic [2*W:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [15:0]  model_cnt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: true result in plain integers, then clamp or wrap.
  function automatic logic [2*W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic op, input logic sg);
    int ai, bi, r, lo, hi, s;
    logic signed [W-1:0] sa, sb;
    logic [W-1:0] wrap;
    logic ovf;
    sa = a;
    sb = b;
    if (sg) begin
      ai = int'(sa);
      bi = int'(sb);
      lo = -(1 << (W - 1));
      hi = (1 << (W - 1)) - 1;
    end else begin
      ai = int'({1'b0, a});
      bi = int'({1'b0, b});
      lo = 0;
      hi = (1 << W) - 1;
    end
    r    = op ? (ai - bi) : (ai + bi);
    ovf  = (r < lo) || (r > hi);
    s    = (r < lo) ? lo : ((r > hi) ? hi : r);
    wrap = r[W-1:0];
    return {ovf, wrap, s[W-1:0]};
  endfunction

  // monitor
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_out;
  logic         prev_ovf;

  initial begin
    logic [2*W:0] e;
    logic         hs;
    logic         beat_ovf;
    forever begin
      @(negedge clk);
      if (!rst_x) begin
        prev_hold = 1'b0;
      end else begin
        chk("ovf_cnt_model", o_ovf_cnt, model_cnt);
        if (prev_hold) begin
          chk("stall_out_stable", o_out, prev_out);
          chk("stall_ovf_stable", o_ovf, prev_ovf);
        end
        hs = o_valid && i_ready;
        beat_ovf = 1'b0;
        if (hs) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected none", o_out);
          end else begin
            e = exp_q.pop_front();
            beat_ovf = e[2*W];
            chk("out_sat", o_out, e[W-1:0]);
            chk("out_wrap", o_out_w, e[2*W-1:W]);
            chk("ovf_sat", o_ovf, e[2*W]);
            chk("ovf_wrap", o_ovf_w, e[2*W]);
          end
        end
        if (i_cnt_clr) model_cnt = '0;
        else if (hs && beat_ovf && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        prev_hold = o_valid && !i_ready;
        prev_out  = o_out;
        prev_ovf  = o_ovf;
      end
    end
  end

  // driver tasks: all start and end just after a rising edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                      input logic sg, input logic [2*W:0] exp, output bit first);
    int tries;
    bit done;
    tries = 0;
    done = 1'b0;
    first = 1'b0;
    i_valid = 1'b1;
    i_in_a = a;
    i_in_b = b;
    i_op = op;
    i_signed = sg;
    while (!done && tries < 200) begin
      @(negedge clk);
      if (o_ready) begin
        exp_q.push_back(exp);
        done = 1'b1;
        first = (tries == 0);
      end
      tries++;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no o_ready expected o_ready within 200 cycles");
      i_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic clr_cnt();
    i_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    i_cnt_clr = 1'b0;
  endtask

  task automatic check_latency(input string nm);
    int cyc;
    bit seen;
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_in_a = 8'h10;
    i_in_b = 8'h20;
    i_op = 1'b0;
    i_signed = 1'b0;
    @(negedge clk);
    chk({nm, "_oready"}, o_ready, 1);
    if (o_ready) exp_q.push_back({1'b0, 8'h30, 8'h30});
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      seen = o_valid;
    end
    chk(nm, cyc, STAGES);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h7F;
      2: return 8'h80;
      3: return 8'hFF;
      4: return 8'h01;
      default: return W'($urandom_range(0, 255));
    endcase
  endfunction

  bit first_tries[5];
  bit ft;
  bit done_rand;

  initial begin
    logic [W-1:0] ra, rb;
    logic rop, rsg;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_out", o_out, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_cnt", o_ovf_cnt, 0);
    rst_x = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_oready", o_ready, 1);

    check_latency("latency_first");

    // unsigned add, subtract modes: {ovf, wrapped, clamped}
    i_ready = 1'b1;
    send(8'h80, 8'h7F, 0, 0, {1'b0, 8'hFF, 8'hFF}, ft);
    send(8'hFF, 8'h02, 0, 0, {1'b1, 8'h01, 8'hFF}, ft);
    send(8'h03, 8'h05, 1, 0, {1'b1, 8'hFE, 8'h00}, ft);
    send(8'h05, 8'h07, 1, 1, {1'b0, 8'hFE, 8'hFE}, ft);
    send(8'h80, 8'h01, 1, 1, {1'b1, 8'h7F, 8'h80}, ft);
    send(8'h7F, 8'h01, 0, 1, {1'b1, 8'h80, 8'h7F}, ft);
    send(8'h40, 8'h40, 0, 0, {1'b0, 8'h80, 8'h80}, ft);
    idle(1);
    drain();

    // backpressure: 5 back-to-back beats with i_ready low for six cycles
    i_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          logic [W-1:0] sv;
          sv = W'(i * 16 + 3);
          send(W'(i * 16 + 1), 8'h02, 0, 0, {1'b0, sv, sv}, ft);
          first_tries[i] = ft;
        end
        idle(1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_hold_valid", o_valid, 1);
        chk("bp_hold_beat0", o_out, 8'h03);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    chk("bp_beat1_direct", first_tries[1], 1);
    chk("bp_oready_fall", first_tries[2], 0);
    drain();

    // bubble collapse
    i_ready = 1'b0;
    send(8'h21, 8'h01, 0, 0, {1'b0, 8'h22, 8'h22}, ft);
    chk("bubble_a_accept", ft, 1);
    idle(2);
    send(8'h31, 8'h01, 0, 0, {1'b0, 8'h32, 8'h32}, ft);
    chk("bubble_b_accept", ft, 1);
    i_valid = 1'b0;
    chk("bubble_full_oready", o_ready, 0);
    chk("bubble_out_a", o_out, 8'h22);
    i_ready = 1'b1;
    drain();

    // randomized traffic with random backpressure and counter clears
    done_rand = 1'b0;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          ra = pick();
          rb = pick();
          rop = 1'($urandom_range(0, 1));
          rsg = 1'($urandom_range(0, 1));
          send(ra, rb, rop, rsg, ref_model(ra, rb, rop, rsg), ft);
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          i_ready = ($urandom_range(0, 3) != 0);
          i_cnt_clr = ($urandom_range(0, 30) == 0);
          @(posedge clk);
          #1;
        end
        i_ready = 1'b1;
        i_cnt_clr = 1'b0;
      end
    join
    drain();

    // counter: three overflowed beats
    clr_cnt();
    send(8'hFF, 8'h02, 0, 0, {1'b1, 8'h01, 8'hFF}, ft);
    send(8'h7F, 8'h01, 0, 1, {1'b1, 8'h80, 8'h7F}, ft);
    send(8'h80, 8'h01, 1, 1, {1'b1, 8'h7F, 8'h80}, ft);
    send(8'h10, 8'h01, 0, 0, {1'b0, 8'h11, 8'h11}, ft);
    idle(1);
    drain();
    chk("cnt_three", o_ovf_cnt, 3);

    // stalled overflowed beat is not counted until taken
    i_ready = 1'b0;
    send(8'hFF, 8'h02, 0, 0, {1'b1, 8'h01, 8'hFF}, ft);
    idle(4);
    chk("cnt_stall_valid", o_valid, 1);
    chk("cnt_stall_ovf", o_ovf, 1);
    chk("cnt_stall_hold", o_ovf_cnt, 3);
    i_ready = 1'b1;
    drain();
    chk("cnt_four", o_ovf_cnt, 4);

    // clear in the same cycle as a counted handshake
    i_ready = 1'b0;
    send(8'h03, 8'h05, 1, 0, {1'b1, 8'hFE, 8'h00}, ft);
    idle(2);
    i_ready = 1'b1;
    i_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    i_cnt_clr = 1'b0;
    chk("cnt_clr_priority", o_ovf_cnt, 0);
    chk("cnt_clr_delivered", exp_q.size(), 0);

    // saturation at 0xFFFF
    for (int n = 0; n < 65535; n++) begin
      rb = W'($urandom_range(1, 255));
      send(8'hFF, rb, 0, 0, {1'b1, 8'(rb - 8'h01), 8'hFF}, ft);
    end
    idle(1);
    drain();
    chk("cnt_reach_max", o_ovf_cnt, 16'hFFFF);
    send(8'hFF, 8'hFF, 0, 0, {1'b1, 8'hFE, 8'hFF}, ft);
    idle(1);
    drain();
    chk("cnt_saturate", o_ovf_cnt, 16'hFFFF);

    // reset while full and stalled
    i_ready = 1'b0;
    send(8'hFF, 8'h02, 0, 0, {1'b1, 8'h01, 8'hFF}, ft);
    send(8'h12, 8'h01, 0, 0, {1'b0, 8'h13, 8'h13}, ft);
    i_valid = 1'b0;
    chk("pre_rst_full", o_ready, 0);
    #1;
    rst_x = 1'b0;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_out", o_out, 0);
    chk("midrst_cnt", o_ovf_cnt, 0);
    exp_q.delete();
    model_cnt = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_x = 1'b1;
    @(posedge clk);
    #1;
    check_latency("latency_after_rst");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
